// File: rtl/kl_pipe_pkg.sv
// Shared definitions for the single-operand-fetch pipeline stage: control field
// offsets, instruction-type bit indices, register-file and scoreboard sizing.
package kl_pipe_pkg;

    localparam int NREG        = 8;
    localparam int REG_IDX_W   = 3;
    localparam int DATA_W      = 16;
    localparam int CNT_W       = 2;
    localparam int CTRL_W      = 22;
    localparam int INST_TYPE_W = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Control word layout: {opcode,PC,asel,bsel,loads,ALUop,shift,write,writenum}
    localparam int CTRL_OPCODE_LSB = 19;
    localparam int CTRL_PC_LSB     = 11;
    localparam int CTRL_ASEL       = 10;
    localparam int CTRL_BSEL       = 9;
    localparam int CTRL_LOADS      = 8;
    localparam int CTRL_ALUOP_LSB  = 6;
    localparam int CTRL_SHIFT_LSB  = 4;
    localparam int CTRL_WRITE      = 3;
    localparam int CTRL_WNUM_LSB   = 0;

    localparam int IT_LDR = 0;
    localparam int IT_STR = 1;
    localparam int IT_BL  = 2;
    localparam int IT_BX  = 3;
    localparam int IT_BLX = 4;
    localparam int IT_RSV = 5;

    localparam int USED_RD = 0;
    localparam int USED_RN = 1;
    localparam int USED_RM = 2;

    typedef enum logic [1:0] {
        OPND_A = 2'd0,
        OPND_B = 2'd1,
        OPND_C = 2'd2
    } opnd_e;

    typedef struct packed {
        logic [CTRL_W-1:0]      control;
        logic [DATA_W-1:0]      val_a;
        logic [DATA_W-1:0]      val_b;
        logic [DATA_W-1:0]      val_c;
        logic [DATA_W-1:0]      sximm;
        logic [INST_TYPE_W-1:0] inst_type;
    } stage_t;

    function automatic logic [REG_IDX_W-1:0] ctrl_writenum(input logic [CTRL_W-1:0] c);
        return c[CTRL_WNUM_LSB +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/pipeline_1_operand_if.sv
// Decode-side, execute-side and writeback signals of the operand stage.
// in_*/out_* follow valid/ready: a transfer happens on a rising edge where both are 1.
interface pipeline_1_operand_if;
    import kl_pipe_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [CTRL_W-1:0]      control_in;
    logic [REG_IDX_W-1:0]   num_Rm;
    logic [REG_IDX_W-1:0]   num_Rn;
    logic [REG_IDX_W-1:0]   num_Rd;
    logic [2:0]             used_RmRnRd;
    logic [INST_TYPE_W-1:0] inst_type_in;
    logic [DATA_W-1:0]      sximm_in;

    logic                   wb_en;
    logic [REG_IDX_W-1:0]   wb_num;
    logic [DATA_W-1:0]      wb_data;
    logic                   flush;

    logic                   out_valid;
    logic                   out_ready;
    logic [CTRL_W-1:0]      control_out;
    logic [DATA_W-1:0]      val_A;
    logic [DATA_W-1:0]      val_B;
    logic [DATA_W-1:0]      val_C;
    logic [DATA_W-1:0]      sximm_out;
    logic [INST_TYPE_W-1:0] inst_type_out;

    modport slave (
        input  in_valid, control_in, num_Rm, num_Rn, num_Rd, used_RmRnRd,
               inst_type_in, sximm_in, wb_en, wb_num, wb_data, flush, out_ready,
        output in_ready, out_valid, control_out, val_A, val_B, val_C,
               sximm_out, inst_type_out
    );

    modport master (
        output in_valid, control_in, num_Rm, num_Rn, num_Rd, used_RmRnRd,
               inst_type_in, sximm_in, wb_en, wb_num, wb_data, flush, out_ready,
        input  in_ready, out_valid, control_out, val_A, val_B, val_C,
               sximm_out, inst_type_out
    );

endinterface

// File: rtl/kl_regfile.sv
// 8x16 register file: async reset, one synchronous write port, three async read ports.
module kl_regfile
    import kl_pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [REG_IDX_W-1:0] raddr_a,
    input  logic [REG_IDX_W-1:0] raddr_b,
    input  logic [REG_IDX_W-1:0] raddr_c,
    output logic [DATA_W-1:0]    rdata_a,
    output logic [DATA_W-1:0]    rdata_b,
    output logic [DATA_W-1:0]    rdata_c
);

    logic [DATA_W-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
    assign rdata_c = mem[raddr_c];

endmodule

// File: rtl/pipeline_1_operand.sv
// Operand-fetch stage: scoreboarded register read with one output register.
// Define OPERAND_BYPASS_EN to forward same-cycle writeback data past a single pending write.
module pipeline_1_operand
    import kl_pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    pipeline_1_operand_if.slave    bus,
    output logic [NREG*CNT_W-1:0]  dbg_sb
);

    logic [CNT_W-1:0]     cnt     [NREG];
    logic [CNT_W-1:0]     cnt_nxt [NREG];
    logic [REG_IDX_W-1:0] op_idx  [3];
    logic [DATA_W-1:0]    op_rf   [3];
    logic [DATA_W-1:0]    op_val  [3];
    logic [2:0]           op_used;
    logic                 hazard;
    logic                 accept;
    logic                 kill;
    logic                 out_valid_q;
    stage_t               stage_q;
    stage_t               stage_d;

    assign op_idx[OPND_A]  = bus.num_Rn;
    assign op_idx[OPND_B]  = bus.num_Rm;
    assign op_idx[OPND_C]  = bus.num_Rd;
    assign op_used[OPND_A] = bus.used_RmRnRd[USED_RN];
    assign op_used[OPND_B] = bus.used_RmRnRd[USED_RM];
    assign op_used[OPND_C] = bus.used_RmRnRd[USED_RD];

    kl_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wb_en),
        .waddr   (bus.wb_num),
        .wdata   (bus.wb_data),
        .raddr_a (op_idx[OPND_A]),
        .raddr_b (op_idx[OPND_B]),
        .raddr_c (op_idx[OPND_C]),
        .rdata_a (op_rf[OPND_A]),
        .rdata_b (op_rf[OPND_B]),
        .rdata_c (op_rf[OPND_C])
    );

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_val[i] = op_used[i] ? op_rf[i] : '0;
`ifdef OPERAND_BYPASS_EN
            if (op_used[i] && bus.wb_en && bus.wb_num == op_idx[i]) op_val[i] = bus.wb_data;
            if (op_used[i] && cnt[op_idx[i]] != '0 &&
                !(cnt[op_idx[i]] == CNT_W'(1) && bus.wb_en && bus.wb_num == op_idx[i]))
                hazard = 1'b1;
`else
            if (op_used[i] && cnt[op_idx[i]] != '0) hazard = 1'b1;
`endif
        end
        // A saturated counter cannot record another in-flight writer.
        if (bus.control_in[CTRL_WRITE] && cnt[ctrl_writenum(bus.control_in)] == CNT_MAX)
            hazard = 1'b1;
    end

    assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign kill         = bus.flush && out_valid_q;

    // Increment, writeback and flush may all hit one register; sum then clamp.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            int v;
            v = int'(cnt[r]);
            if (accept && bus.control_in[CTRL_WRITE] &&
                ctrl_writenum(bus.control_in) == REG_IDX_W'(r)) v = v + 1;
            if (bus.wb_en && bus.wb_num == REG_IDX_W'(r)) v = v - 1;
            if (kill && stage_q.control[CTRL_WRITE] &&
                ctrl_writenum(stage_q.control) == REG_IDX_W'(r)) v = v - 1;
            if (v < 0) v = 0;
            if (v > int'(CNT_MAX)) v = int'(CNT_MAX);
            cnt_nxt[r] = CNT_W'(v);
        end
    end

    always_comb begin
        stage_d           = '0;
        stage_d.control   = bus.control_in;
        stage_d.val_a     = op_val[OPND_A];
        stage_d.val_b     = op_val[OPND_B];
        stage_d.val_c     = op_val[OPND_C];
        stage_d.sximm     = bus.sximm_in;
        stage_d.inst_type = bus.inst_type_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            stage_q     <= '0;
            for (int r = 0; r < NREG; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
            if (accept) begin
                out_valid_q <= 1'b1;
                stage_q     <= stage_d;
            end else if (kill) begin
                out_valid_q <= 1'b0;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.control_out   = stage_q.control;
    assign bus.val_A         = stage_q.val_a;
    assign bus.val_B         = stage_q.val_b;
    assign bus.val_C         = stage_q.val_c;
    assign bus.sximm_out     = stage_q.sximm;
    assign bus.inst_type_out = stage_q.inst_type;

    always_comb begin
        dbg_sb = '0;
        for (int r = 0; r < NREG; r++) dbg_sb[r*CNT_W +: CNT_W] = cnt[r];
    end

endmodule

// File: tb/tb_pipeline_1_operand.sv
// Bench for pipeline_1_operand: directed scenarios then random traffic against a
// queue-based reference of pending writers, register contents and held instruction.
module tb_pipeline_1_operand;
  import kl_pipe_pkg::*;

`ifdef OPERAND_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [15:0] dbg_sb;
  always #5 clk = ~clk;

  pipeline_1_operand_if bus();

  pipeline_1_operand dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .dbg_sb (dbg_sb)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: pending writer counts, architectural registers, held record.
  int          pend [8];
  logic [15:0] regs [8];
  logic [91:0] exp_q[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pack_pend();
    logic [15:0] p;
    p = '0;
    for (int r = 0; r < 8; r++) p[r*2 +: 2] = 2'(pend[r]);
    return p;
  endfunction

  task automatic set_idle();
    bus.in_valid     = 1'b0;
    bus.control_in   = 22'($urandom);
    bus.control_in[3] = 1'b0;
    bus.num_Rm       = 3'($urandom);
    bus.num_Rn       = 3'($urandom);
    bus.num_Rd       = 3'($urandom);
    bus.used_RmRnRd  = 3'b000;
    bus.inst_type_in = 6'($urandom);
    bus.sximm_in     = 16'($urandom);
    bus.wb_en        = 1'b0;
    bus.wb_num       = 3'd0;
    bus.wb_data      = 16'd0;
    bus.flush        = 1'b0;
    bus.out_ready    = 1'b1;
  endtask

  task automatic set_inst(input bit wr, input logic [2:0] wn, input logic [2:0] rn,
                          input logic [2:0] rm, input logic [2:0] rd,
                          input logic [2:0] used, input logic [5:0] it);
    logic [21:0] c;
    c = 22'($urandom);
    c[3] = wr;
    c[2:0] = wn;
    bus.in_valid     = 1'b1;
    bus.control_in   = c;
    bus.num_Rn       = rn;
    bus.num_Rm       = rm;
    bus.num_Rd       = rd;
    bus.used_RmRnRd  = used;
    bus.inst_type_in = it;
    bus.sximm_in     = 16'($urandom);
  endtask

  task automatic set_wb(input bit en, input logic [2:0] num, input logic [15:0] data);
    bus.wb_en   = en;
    bus.wb_num  = num;
    bus.wb_data = data;
  endtask

  // One clock: check in_ready mid-cycle, advance the reference, check outputs after the edge.
  task automatic step();
    logic [2:0]  oi [3];
    bit          ou [3];
    logic [15:0] ov [3];
    bit          blocked, rdy, acc, kill;
    logic [91:0] rec;
    logic [91:0] obs;
    int          wn;
    #3;
    oi = '{bus.num_Rn, bus.num_Rm, bus.num_Rd};
    ou = '{bus.used_RmRnRd[1], bus.used_RmRnRd[2], bus.used_RmRnRd[0]};
    blocked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ov[k] = 16'd0;
      if (ou[k]) begin
        if (pend[oi[k]] > 0 &&
            !(BYP && pend[oi[k]] == 1 && bus.wb_en && bus.wb_num == oi[k]))
          blocked = 1'b1;
        ov[k] = (BYP && bus.wb_en && bus.wb_num == oi[k]) ? bus.wb_data : regs[oi[k]];
      end
    end
    if (bus.control_in[3] && pend[bus.control_in[2:0]] >= 3) blocked = 1'b1;
    rdy = !blocked && (exp_q.size() == 0 || bus.out_ready);
    chk("in_ready", 96'(bus.in_ready), 96'(rdy));
    acc  = bus.in_valid && rdy;
    kill = bus.flush && exp_q.size() != 0;
    if (kill) begin
      rec = exp_q.pop_front();
      wn = int'(rec[72:70]);
      if (rec[73] && pend[wn] > 0) pend[wn]--;
    end else if (exp_q.size() != 0 && bus.out_ready) begin
      void'(exp_q.pop_front());
    end
    if (acc) begin
      exp_q.push_back({bus.control_in, ov[0], ov[1], ov[2], bus.sximm_in, bus.inst_type_in});
      if (bus.control_in[3]) pend[bus.control_in[2:0]]++;
    end
    if (bus.wb_en) begin
      if (pend[bus.wb_num] > 0) pend[bus.wb_num]--;
      regs[bus.wb_num] = bus.wb_data;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 96'(bus.out_valid), 96'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      obs = {bus.control_out, bus.val_A, bus.val_B, bus.val_C, bus.sximm_out, bus.inst_type_out};
      chk("stage_out", 96'(obs), 96'(exp_q[0]));
    end
    chk("scoreboard", 96'(dbg_sb), 96'(pack_pend()));
  endtask

  // Reset asserted between clock edges; its effect must be visible before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_out_valid", 96'(bus.out_valid), 96'(0));
    chk("rst_outputs", 96'({bus.control_out, bus.val_A, bus.val_B, bus.val_C,
                            bus.sximm_out, bus.inst_type_out}), 96'(0));
    chk("rst_scoreboard", 96'(dbg_sb), 96'(0));
    for (int r = 0; r < 8; r++) begin
      pend[r] = 0;
      regs[r] = 16'd0;
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    set_idle();
    step();
    for (int r = 0; r < 8; r++) begin
      for (int g = 0; g < 4 && pend[r] > 0; g++) begin
        set_idle();
        set_wb(1'b1, 3'(r), 16'($urandom));
        step();
      end
    end
    set_idle();
  endtask

  initial begin
    int cand [$];
    rst = 1'b1;
    set_idle();
    @(posedge clk);
    #1;
    do_reset();

    // Independent instructions back to back: MOV R1,#5 then ADD R2,R3,R4.
    set_inst(1'b1, 3'd1, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000000); step();
    set_inst(1'b1, 3'd2, 3'd3, 3'd4, 3'd0, 3'b110, 6'b000000); step();
    chk("mov_pending_r1", 96'(dbg_sb[3:2]), 96'(1));

    // RAW on R1: stalls until the writeback of 5.
    set_inst(1'b1, 3'd5, 3'd1, 3'd3, 3'd0, 3'b110, 6'b000000); step();
    set_wb(1'b1, 3'd1, 16'h0005); step();
    set_wb(1'b0, 3'd0, 16'h0000);
    if (BYP) set_idle();
    step();
    chk("raw_val_A", 96'(bus.val_A), 96'(16'h0005));
    drain();

    // Backpressure: output frozen for three cycles.
    set_inst(1'b0, 3'd0, 3'd2, 3'd7, 3'd1, 3'b111, 6'b000010); step();
    set_inst(1'b1, 3'd4, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000000);
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.out_ready = 1'b1;
    step();
    drain();

    // Flush a held LDR R5.
    set_inst(1'b1, 3'd5, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000001);
    bus.out_ready = 1'b0;
    step();
    set_idle();
    bus.out_ready = 1'b0;
    bus.flush = 1'b1;
    step();
    chk("flush_pending_r5", 96'(dbg_sb[11:10]), 96'(0));
    set_idle();
    step();

    // Saturation: fourth writer to R6 waits for a writeback.
    repeat (3) begin
      set_inst(1'b1, 3'd6, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000000); step();
    end
    set_inst(1'b1, 3'd6, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000000);
    repeat (2) step();
    set_wb(1'b1, 3'd6, 16'hBEEF); step();
    set_wb(1'b0, 3'd0, 16'h0000); step();
    chk("sat_pending_r6", 96'(dbg_sb[13:12]), 96'(3));
    drain();

    // Reset mid-stall, then R0 reads back as zero.
    set_inst(1'b1, 3'd1, 3'd0, 3'd0, 3'd0, 3'b000, 6'b000000); step();
    set_wb(1'b1, 3'd0, 16'h1234); step();
    set_wb(1'b0, 3'd0, 16'h0000);
    set_inst(1'b0, 3'd0, 3'd1, 3'd0, 3'd0, 3'b010, 6'b000000); step();
    do_reset();
    set_inst(1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b010, 6'b000000); step();
    chk("post_rst_val_A", 96'(bus.val_A), 96'(0));

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      set_idle();
      if ($urandom_range(0, 3) != 0)
        set_inst(1'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                 3'($urandom), 6'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int r = 0; r < 8; r++) if (pend[r] > 0) cand.push_back(r);
      if (cand.size() != 0 && $urandom_range(0, 9) < 4)
        set_wb(1'b1, 3'(cand[$urandom_range(0, cand.size() - 1)]), 16'($urandom));
      if (!bus.in_valid && $urandom_range(0, 9) == 0) bus.flush = 1'b1;
      step();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
